// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of issued branch predictions.
// Each prediction is matched against the resolved outcome from execute.
// The queue produces predictor training updates and flags mispredictions;
// a mispredict flushes younger wrong-path entries. Saturating counters
// track resolved branches and mispredictions.
module branch_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       pred_valid,
    input  logic [PC_W-1:0]            pred_pc,
    input  logic                       pred_taken,
    output logic                       pred_ready,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    output logic                       upd_valid,
    output logic [PC_W-1:0]            upd_pc,
    output logic                       upd_taken,
    output logic                       mispredict,
    output logic [PC_W-1:0]            mispredict_pc,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           branch_count,
    output logic [CNT_W-1:0]           mispredict_count,
    output logic                       underflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Entry storage; written only on an accepted push, never reset.
    logic [PC_W-1:0]  mem_pc_q [DEPTH];
    logic [DEPTH-1:0] mem_pred_q;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             upd_valid_q, upd_valid_d;
    logic [PC_W-1:0]  upd_pc_q, upd_pc_d;
    logic             upd_taken_q, upd_taken_d;
    logic             mispredict_q, mispredict_d;
    logic [PC_W-1:0]  mispredict_pc_q, mispredict_pc_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;
    logic             underflow_err_q, underflow_err_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             wrong;
    logic             mem_we;
    logic [PC_W-1:0]  head_pc;
    logic             head_pred;

    assign full      = (occ_q == OCC_W'(DEPTH));
    assign empty     = (occ_q == '0);
    assign head_pc   = mem_pc_q[rd_ptr_q];
    assign head_pred = mem_pred_q[rd_ptr_q];
    // Readiness comes from registered occupancy only; a same-cycle pop does not free a slot.
    assign push      = pred_valid && !full;
    assign pop       = resolve_valid && !empty;
    assign wrong     = pop && (resolve_taken != head_pred);
    // A mispredicting pop drops any push in the same cycle: it is on the wrong path.
    assign mem_we    = push && !wrong;

    // Next-state computation for pointers, occupancy, pop outputs and statistics.
    always_comb begin
        wr_ptr_d           = wr_ptr_q;
        rd_ptr_d           = rd_ptr_q;
        occ_d              = occ_q;
        upd_valid_d        = 1'b0;
        upd_pc_d           = upd_pc_q;
        upd_taken_d        = upd_taken_q;
        mispredict_d       = 1'b0;
        mispredict_pc_d    = mispredict_pc_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        underflow_err_d    = underflow_err_q;

        if (pop) begin
            upd_valid_d    = 1'b1;
            upd_pc_d       = head_pc;
            upd_taken_d    = resolve_taken;
            rd_ptr_d       = rd_ptr_q + PTR_W'(1);
            branch_count_d = sat_inc(branch_count_q);
        end

        if (wrong) begin
            // Flush: everything younger than the head is wrong-path work.
            mispredict_d       = 1'b1;
            mispredict_pc_d    = head_pc;
            wr_ptr_d           = rd_ptr_q + PTR_W'(1);
            occ_d              = '0;
            mispredict_count_d = sat_inc(mispredict_count_q);
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end

        if (resolve_valid && empty) begin
            underflow_err_d = 1'b1;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q           <= '0;
            rd_ptr_q           <= '0;
            occ_q              <= '0;
            upd_valid_q        <= 1'b0;
            upd_pc_q           <= '0;
            upd_taken_q        <= 1'b0;
            mispredict_q       <= 1'b0;
            mispredict_pc_q    <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
            underflow_err_q    <= 1'b0;
        end else begin
            wr_ptr_q           <= wr_ptr_d;
            rd_ptr_q           <= rd_ptr_d;
            occ_q              <= occ_d;
            upd_valid_q        <= upd_valid_d;
            upd_pc_q           <= upd_pc_d;
            upd_taken_q        <= upd_taken_d;
            mispredict_q       <= mispredict_d;
            mispredict_pc_q    <= mispredict_pc_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
            underflow_err_q    <= underflow_err_d;
        end
    end

    // Entry write on accepted, non-flushed push; gated off during reset.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem_pc_q[wr_ptr_q]   <= pred_pc;
            mem_pred_q[wr_ptr_q] <= pred_taken;
        end
    end

    assign pred_ready       = !full;
    assign occupancy        = occ_q;
    assign upd_valid        = upd_valid_q;
    assign upd_pc           = upd_pc_q;
    assign upd_taken        = upd_taken_q;
    assign mispredict       = mispredict_q;
    assign mispredict_pc    = mispredict_pc_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
    assign underflow_err    = underflow_err_q;

endmodule
